suma_c2: RTL and testbench

//  Registered two's-complement adder: s = a + b + ci over ANCHO bits.
//  - Also produces the carry-out and a signed-overflow flag.
//  - Datapath leaf used by the ALU/arithmetic units.
//  - Adder core: 4-bit carry-lookahead groups with rippled group carries.
//  - Results are registered: 1-cycle latency.

---
 rtl/suma_c2.sv | 74 +++++++
 tb/tb_suma_c2.sv | 118 +++++++++++
 2 files changed

// File: rtl/suma_c2.sv
// Registered ANCHO-bit two's-complement adder built from 4-bit carry-lookahead
// groups with rippled group carries; exports carry-out and signed overflow.
module suma_c2 #(
    parameter int ANCHO = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  logic             ci,
    output logic [ANCHO-1:0] s,
    output logic             coutfin,
    output logic             ovf
);

    localparam int NG = ANCHO / 4;

    logic [ANCHO-1:0] g_s;
    logic [ANCHO-1:0] p_s;
    logic [ANCHO:0]   c_s;
    logic [NG-1:0]    gg_s;
    logic [NG-1:0]    gp_s;
    logic [ANCHO-1:0] sum_s;
    logic             ovf_s;

    logic [ANCHO-1:0] s_r;
    logic             coutfin_r;
    logic             ovf_r;

    assign g_s    = a & b;
    assign p_s    = a ^ b;
    assign c_s[0] = ci;

    // Each group derives its internal carries from its own carry-in only;
    // the group carry-out then ripples into the next group.
    for (genvar k = 0; k < NG; k++) begin : g_cla
        localparam int B = 4 * k;

        assign c_s[B+1] = g_s[B] | (p_s[B] & c_s[B]);
        assign c_s[B+2] = g_s[B+1] | (p_s[B+1] & g_s[B])
                        | (p_s[B+1] & p_s[B] & c_s[B]);
        assign c_s[B+3] = g_s[B+2] | (p_s[B+2] & g_s[B+1])
                        | (p_s[B+2] & p_s[B+1] & g_s[B])
                        | (p_s[B+2] & p_s[B+1] & p_s[B] & c_s[B]);

        assign gg_s[k] = g_s[B+3] | (p_s[B+3] & g_s[B+2])
                       | (p_s[B+3] & p_s[B+2] & g_s[B+1])
                       | (p_s[B+3] & p_s[B+2] & p_s[B+1] & g_s[B]);
        assign gp_s[k] = p_s[B+3] & p_s[B+2] & p_s[B+1] & p_s[B];

        assign c_s[B+4] = gg_s[k] | (gp_s[k] & c_s[B]);
    end

    assign sum_s = p_s ^ c_s[ANCHO-1:0];
    assign ovf_s = c_s[ANCHO] ^ c_s[ANCHO-1];

    // Result register; reset clears everything regardless of operand values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_r       <= {ANCHO{1'b0}};
            coutfin_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            s_r       <= sum_s;
            coutfin_r <= c_s[ANCHO];
            ovf_r     <= ovf_s;
        end
    end

    assign s       = s_r;
    assign coutfin = coutfin_r;
    assign ovf     = ovf_r;

endmodule

// File: tb/tb_suma_c2.sv
// Directed and random checks of suma_c2 (ANCHO=64): reset, wrap, carry-out,
// signed overflow, operand symmetry, hold behaviour and mid-stream reset.
module tb_suma_c2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic [63:0] s;
    logic        coutfin;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    suma_c2 #(.ANCHO(64)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .ci(ci),
        .s(s), .coutfin(coutfin), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Observed/expected values are packed as {ovf, coutfin, s}.
    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] ref_sum(input logic [63:0] ra, input logic [63:0] rb,
                                            input logic rci);
        logic [64:0] t;
        logic        v;
        t = {1'b0, ra} + {1'b0, rb} + {64'd0, rci};
        v = (ra[63] == rb[63]) && (t[63] != ra[63]);
        return {v, t};
    endfunction

    task automatic apply(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                         input logic tci, input logic [65:0] exp);
        a  = ta;
        b  = tb;
        ci = tci;
        @(posedge clk);
        #1;
        chk(tag, {ovf, coutfin, s}, exp);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rci;

        rst_n = 1'b0;
        a     = 64'hxxxx_xxxx_xxxx_xxxx;
        b     = 64'hxxxx_xxxx_xxxx_xxxx;
        ci    = 1'bx;
        @(posedge clk); #1;
        chk("rst0", {ovf, coutfin, s}, 66'h0);
        a  = 64'hFFFF_FFFF_FFFF_FFFF;
        b  = 64'hFFFF_FFFF_FFFF_FFFF;
        ci = 1'b1;
        @(posedge clk); #1;
        chk("rst1", {ovf, coutfin, s}, 66'h0);
        rst_n = 1'b1;

        apply("ones_p1",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0,
              66'h1_0000_0000_0000_0000);
        apply("ones_p1_sw", 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              66'h1_0000_0000_0000_0000);
        apply("minmin",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
              66'h3_0000_0000_0000_0000);
        apply("maxp1",    64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0,
              66'h2_8000_0000_0000_0000);
        apply("maxp1_sw", 64'h0000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0,
              66'h2_8000_0000_0000_0000);
        apply("zero_ci",  64'h0, 64'h0, 1'b1, 66'h0_0000_0000_0000_0001);
        apply("small",    64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 1'b0,
              66'h0_0000_0000_0000_0008);
        apply("grp_carry", 64'h0000_0000_0000_000F, 64'h0000_0000_0000_0001, 1'b0,
              66'h0_0000_0000_0000_0010);
        apply("neg_neg",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              66'h1_FFFF_FFFF_FFFF_FFFE);
        apply("neg_ovf",  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              66'h3_7FFF_FFFF_FFFF_FFFF);
        apply("ones_ci",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              66'h1_FFFF_FFFF_FFFF_FFFF);

        // New inputs must not reach the outputs before the next edge.
        a  = 64'h0;
        b  = 64'h0;
        ci = 1'b0;
        #2;
        chk("hold", {ovf, coutfin, s}, 66'h1_FFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        chk("after_hold", {ovf, coutfin, s}, 66'h0);

        for (int i = 0; i < 40; i++) begin
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            rci = 1'($urandom);
            if (i == 20) begin
                rst_n = 1'b0;
                apply("mid_rst", ra, rb, rci, 66'h0);
                rst_n = 1'b1;
            end else begin
                apply($sformatf("rand%0d", i), ra, rb, rci, ref_sum(ra, rb, rci));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
